// File: rtl/mul_final_stage.sv
`default_nettype none
// ============================================================================
// Module   : mul_final_stage
// Function : Multiplier final carry-propagate stage. Captures the redundant
//            sum/carry rows from the compressor tree (S1), resolves them with
//            a full-width add and selects the RV64M result (S2), and delivers
//            it through a valid/ready output with backpressure and flush.
// Revision : 1.0 - initial release
// ============================================================================
module mul_final_stage #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*XLEN-1:0]   in_sum,
  input  logic [2*XLEN-1:0]   in_carry,
  input  logic [2:0]          in_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag
);

  localparam logic [2:0] c_OP_MUL    = 3'd0;
  localparam logic [2:0] c_OP_MULH   = 3'd1;
  localparam logic [2:0] c_OP_MULHSU = 3'd2;
  localparam logic [2:0] c_OP_MULHU  = 3'd3;
  localparam logic [2:0] c_OP_MULW   = 3'd4;

  // S1 operand capture
  logic                r_s1_valid;
  logic [2*XLEN-1:0]   r_s1_sum;
  logic [2*XLEN-1:0]   r_s1_carry;
  logic [2:0]          r_s1_op;
  logic [TAG_W-1:0]    r_s1_tag;

  // S2 result
  logic                r_s2_valid;
  logic [XLEN-1:0]     r_s2_result;
  logic [TAG_W-1:0]    r_s2_tag;

  logic                w_s2_adv;
  logic                w_accept;
  logic                w_out_fire;
  logic [2*XLEN-1:0]   w_full;
  logic [XLEN-1:0]     w_sel;

  // S1 moves into S2 whenever S2 is empty or is draining this cycle
  assign w_s2_adv   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s2_adv;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  // Carry-propagate add; signedness was resolved upstream, carry-out dropped
  assign w_full = r_s1_sum + r_s1_carry;

  // Result selection by operation; reserved codes yield zero
  always_comb begin
    w_sel = '0;
    case (r_s1_op)
      c_OP_MUL:                          w_sel = w_full[XLEN-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_sel = w_full[2*XLEN-1:XLEN];
      c_OP_MULW:                         w_sel = {{(XLEN-32){w_full[31]}}, w_full[31:0]};
      default:                           w_sel = '0;
    endcase
  end

  // Valid bits: reset and flush empty both stages, otherwise follow handshakes
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_accept)
        r_s1_valid <= 1'b1;
      else if (w_s2_adv)
        r_s1_valid <= 1'b0;

      if (w_s2_adv)
        r_s2_valid <= 1'b1;
      else if (w_out_fire)
        r_s2_valid <= 1'b0;
    end
  end

  // Data payload registers carry no reset; their valid bits qualify them
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_sum   <= in_sum;
      r_s1_carry <= in_carry;
      r_s1_op    <= in_op;
      r_s1_tag   <= in_tag;
    end
    if (w_s2_adv) begin
      r_s2_result <= w_sel;
      r_s2_tag    <= r_s1_tag;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_mul_final_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_final_stage
// Function : Self-checking bench for mul_final_stage with a queue scoreboard
//            fed from accepted inputs and drained by an output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_final_stage;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2*XLEN-1:0] in_sum;
  logic [2*XLEN-1:0] in_carry;
  logic [2:0]        in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [TAG_W-1:0]  out_tag;

  mul_final_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: add the rows as plain 128-bit integers, then pick by opcode
  function automatic logic [XLEN-1:0] ref_result(input logic [2*XLEN-1:0] s,
                                                 input logic [2*XLEN-1:0] c,
                                                 input logic [2:0] op);
    logic [2*XLEN-1:0] f;
    logic [XLEN-1:0]   r;
    f = s + c;
    if (op == 3'd0)      r = f[XLEN-1:0];
    else if (op <= 3'd3) r = f[2*XLEN-1:XLEN];
    else if (op == 3'd4) r = XLEN'($signed(f[31:0]));
    else                 r = '0;
    return r;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: pop/compare on output handshake, drop in-flight on flush or
  // reset, push expected on input handshake, check stall stability
  logic             p_stall = 1'b0;
  logic [XLEN-1:0]  p_res;
  logic [TAG_W-1:0] p_tag;
  always @(negedge clk) begin
    exp_t e;
    if (p_stall) begin
      check("stall_valid", XLEN'(out_valid), XLEN'(1));
      check("stall_result", out_result, p_res);
      check("stall_tag", XLEN'(out_tag), XLEN'(p_tag));
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: tag=%0d result=%h with empty scoreboard", out_tag, out_result);
      end else begin
        e = exp_q.pop_front();
        check("out_tag", XLEN'(out_tag), XLEN'(e.tag));
        check("out_result", out_result, e.result);
      end
    end
    if (!rst_n || flush)
      exp_q.delete();
    else if (in_valid && in_ready) begin
      e.result = ref_result(in_sum, in_carry, in_op);
      e.tag    = in_tag;
      exp_q.push_back(e);
    end
    p_stall = rst_n && !flush && out_valid && !out_ready;
    p_res   = out_result;
    p_tag   = out_tag;
  end

  // Offer one op and hold it until accepted (bounded)
  task automatic send(input logic [2*XLEN-1:0] s, input logic [2*XLEN-1:0] c,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    in_valid = 1'b1; in_sum = s; in_carry = c; in_op = op; in_tag = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: tag=%0d never accepted", tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cycles(1);
    check("drain_empty", XLEN'(exp_q.size()), XLEN'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0; in_op = '0; in_tag = '0;

    // Reset and idle
    cycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", XLEN'(out_valid), XLEN'(0));
    check("reset_in_ready", XLEN'(in_ready), XLEN'(1));
    cycles(3);
    check("idle_out_valid", XLEN'(out_valid), XLEN'(0));

    // Basic MUL with latency check: accepted at edge N, valid after N+1
    send(128'd3, 128'd4, 3'd0, 5'd7);
    check("lat_not_yet", XLEN'(out_valid), XLEN'(0));
    cycles(1);
    check("lat_valid", XLEN'(out_valid), XLEN'(1));
    check("basic_result", out_result, 64'd7);
    check("basic_tag", XLEN'(out_tag), XLEN'(7));
    drain();

    // High half with wrap, then MULHU of 2^64
    send({1'b1, 127'd0}, {1'b1, 127'd0}, 3'd1, 5'd8);
    send(128'h1_0000_0000_0000_0000, 128'd0, 3'd3, 5'd9);
    // MULW sign extension and reserved op
    send(128'h7FFF_FFFF, 128'd1, 3'd4, 5'd10);
    send(128'h1234, 128'h5678, 3'd6, 5'd11);
    drain();
    check("mulw_model", ref_result(128'h7FFF_FFFF, 128'd1, 3'd4), 64'hFFFF_FFFF_8000_0000);

    // Backpressure: two fit, the third waits
    out_ready = 1'b0;
    send(128'd1, 128'd1, 3'd0, 5'd1);
    send(128'd2, 128'd2, 3'd0, 5'd2);
    in_valid = 1'b1; in_sum = 128'd3; in_carry = 128'd3; in_op = 3'd0; in_tag = 5'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", XLEN'(in_ready), XLEN'(0));
      check("bp_hold_tag", XLEN'(out_tag), XLEN'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", XLEN'(in_ready), XLEN'(1));
    check("bp_first_tag", XLEN'(out_tag), XLEN'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_tag", XLEN'(out_tag), XLEN'(2));
    check("bp_second_valid", XLEN'(out_valid), XLEN'(1));
    cycles(1);
    check("bp_third_tag", XLEN'(out_tag), XLEN'(3));
    check("bp_third_valid", XLEN'(out_valid), XLEN'(1));
    drain();

    // Flush with both stages full and a new op offered in the same cycle
    out_ready = 1'b0;
    send(128'd5, 128'd5, 3'd0, 5'd20);
    send(128'd6, 128'd6, 3'd0, 5'd21);
    in_valid = 1'b1; in_sum = 128'd9; in_op = 3'd0; in_tag = 5'd30; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", XLEN'(out_valid), XLEN'(0));
    check("flush_in_ready", XLEN'(in_ready), XLEN'(1));
    out_ready = 1'b1;
    cycles(5);
    check("flush_stays_empty", XLEN'(out_valid), XLEN'(0));

    // Random stream with random backpressure and occasional flush
    for (int n = 0; n < 1000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_sum    = {$urandom, $urandom, $urandom, $urandom};
      in_carry  = {$urandom, $urandom, $urandom, $urandom};
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      cycles(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drain();
    cycles(2);
    check("final_idle", XLEN'(out_valid), XLEN'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
